// File: rtl/ram_fifo_pkg.sv
// Shared helpers for the RAM FIFO controller: width calculation and error-mode selectors.
package ram_fifo_pkg;

   localparam int ERR_STICKY  = 0;
   localparam int ERR_DYNAMIC = 1;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Modulo-DEPTH wrapping pointer. It wraps at DEPTH-1, so non power-of-2 depths
// never reach addresses at or beyond DEPTH.
module ram_fifo_ptr #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [AW-1:0] ptr_q;
   logic [AW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/ram_r_w_fifo_ctl.sv
// FIFO controller for a dual-address RAM: owns the pointers, occupancy count, status flags
// and error, and drives the RAM strobes combinationally from the accepted requests.
module ram_r_w_fifo_ctl
   import ram_fifo_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int AE_LEVEL = 1,
   parameter int AF_LEVEL = 1,
   parameter int ERR_MODE = ERR_STICKY,
   parameter int AW       = clog2(DEPTH),
   parameter int CW       = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_req_n,
   input  logic          pop_req_n,
   output logic          ram_cs_n,
   output logic          ram_wr_n,
   output logic [AW-1:0] ram_wr_addr,
   output logic [AW-1:0] ram_rd_addr,
   output logic          empty,
   output logic          almost_empty,
   output logic          half_full,
   output logic          almost_full,
   output logic          full,
   output logic          error,
   output logic [CW-1:0] word_count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [CW-1:0] HF_C    = CW'((DEPTH + 1) / 2);
   localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_LEVEL);

   logic          push_ok;
   logic          pop_ok;
   logic          overflow;
   logic          underflow;
   logic [CW-1:0] count_q,  count_d;
   logic          empty_q,  empty_d;
   logic          aempty_q, aempty_d;
   logic          hfull_q,  hfull_d;
   logic          afull_q,  afull_d;
   logic          full_q,   full_d;
   logic          error_q,  error_d;

   // Gating with rst_n keeps the RAM strobes inactive for the whole reset window.
   assign push_ok   = rst_n & ~push_req_n & ~full_q;
   assign pop_ok    = rst_n & ~pop_req_n  & ~empty_q;
   assign overflow  = ~push_req_n & full_q;
   assign underflow = ~pop_req_n  & empty_q;

   assign ram_wr_n = ~push_ok;
   assign ram_cs_n = ~(push_ok | pop_ok);

   ram_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push_ok),
      .ptr   (ram_wr_addr)
   );

   ram_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop_ok),
      .ptr   (ram_rd_addr)
   );

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Flags follow the next count so they line up with word_count after the edge.
      empty_d  = (count_d == '0);
      aempty_d = (count_d <= AE_C);
      hfull_d  = (count_d >= HF_C);
      afull_d  = (count_d >= AF_C);
      full_d   = (count_d == DEPTH_C);
      if (ERR_MODE == ERR_DYNAMIC) begin
         error_d = overflow | underflow;
      end else begin
         error_d = error_q | overflow | underflow;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         hfull_q  <= 1'b0;
         afull_q  <= 1'b0;
         full_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         hfull_q  <= hfull_d;
         afull_q  <= afull_d;
         full_q   <= full_d;
         error_q  <= error_d;
      end
   end

   assign word_count   = count_q;
   assign empty        = empty_q;
   assign almost_empty = aempty_q;
   assign half_full    = hfull_q;
   assign almost_full  = afull_q;
   assign full         = full_q;
   assign error        = error_q;

endmodule

// File: tb/tb_ram_r_w_fifo_ctl.sv
// Directed bench: DEPTH=8 sticky and dynamic-error instances on shared requests with a RAM
// model, plus a DEPTH=6 instance for non power-of-2 pointer wrap.
module tb_ram_r_w_fifo_ctl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       push_n, pop_n, push2_n, pop2_n;
   logic [7:0] din;
   logic [7:0] mem [0:7];
   logic [7:0] rdata;

   logic       cs_n0, wr_n0, empty0, ae0, hf0, af0, full0, err0;
   logic [2:0] wa0, ra0;
   logic [3:0] cnt0;
   logic       cs_n1, wr_n1, empty1, ae1, hf1, af1, full1, err1;
   logic [2:0] wa1, ra1;
   logic [3:0] cnt1;
   logic       cs_n2, wr_n2, empty2, ae2, hf2, af2, full2, err2;
   logic [2:0] wa2, ra2;
   logic [2:0] cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_r_w_fifo_ctl #(.DEPTH(8), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .push_req_n(push_n), .pop_req_n(pop_n),
      .ram_cs_n(cs_n0), .ram_wr_n(wr_n0), .ram_wr_addr(wa0), .ram_rd_addr(ra0),
      .empty(empty0), .almost_empty(ae0), .half_full(hf0), .almost_full(af0),
      .full(full0), .error(err0), .word_count(cnt0));

   ram_r_w_fifo_ctl #(.DEPTH(8), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .push_req_n(push_n), .pop_req_n(pop_n),
      .ram_cs_n(cs_n1), .ram_wr_n(wr_n1), .ram_wr_addr(wa1), .ram_rd_addr(ra1),
      .empty(empty1), .almost_empty(ae1), .half_full(hf1), .almost_full(af1),
      .full(full1), .error(err1), .word_count(cnt1));

   ram_r_w_fifo_ctl #(.DEPTH(6), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .push_req_n(push2_n), .pop_req_n(pop2_n),
      .ram_cs_n(cs_n2), .ram_wr_n(wr_n2), .ram_wr_addr(wa2), .ram_rd_addr(ra2),
      .empty(empty2), .almost_empty(ae2), .half_full(hf2), .almost_full(af2),
      .full(full2), .error(err2), .word_count(cnt2));

   // RAM model for u0: write while strobed, asynchronous read at the read address.
   always @(posedge clk) begin
      if (!wr_n0) mem[wa0] <= din;
   end
   assign rdata = mem[ra0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; push_n = 1'b0; pop_n = 1'b1; push2_n = 1'b1; pop2_n = 1'b1; din = 8'h00;

      // Reset state, with a push request held low to show the strobes stay inactive.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty0), 32'd1);
      chk("rst_aempty", 32'(ae0), 32'd1);
      chk("rst_count", 32'(cnt0), 32'd0);
      chk("rst_wr_n", 32'(wr_n0), 32'd1);
      chk("rst_cs_n", 32'(cs_n0), 32'd1);
      chk("rst_full", 32'(full0), 32'd0);
      chk("rst_afull", 32'(af0), 32'd0);
      chk("rst_hfull", 32'(hf0), 32'd0);
      chk("rst_error", 32'(err0), 32'd0);
      chk("rst_wr_addr", 32'(wa0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; push_n = 1'b1;

      // Fill with A0..A7.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         push_n = 1'b0; din = 8'hA0 + 8'(i);
         #1;
         chk("push_wr_n", 32'(wr_n0), 32'd0);
         chk("push_cs_n", 32'(cs_n0), 32'd0);
         chk("push_wr_addr", 32'(wa0), 32'(i));
         @(posedge clk); #1;
         chk("push_count", 32'(cnt0), 32'(i + 1));
         chk("push_empty", 32'(empty0), 32'd0);
         chk("push_aempty", 32'(ae0), 32'((i + 1) <= 1));
         chk("push_hfull", 32'(hf0), 32'((i + 1) >= 4));
         chk("push_afull", 32'(af0), 32'((i + 1) >= 7));
         chk("push_full", 32'(full0), 32'((i + 1) == 8));
      end

      // Ninth push is rejected: no write strobe, error on the next edge.
      @(negedge clk);
      din = 8'hFF;
      #1;
      chk("ovf_wr_n", 32'(wr_n0), 32'd1);
      chk("ovf_cs_n", 32'(cs_n0), 32'd1);
      @(posedge clk); #1;
      chk("ovf_count", 32'(cnt0), 32'd8);
      chk("ovf_wr_addr", 32'(wa0), 32'd0);
      chk("ovf_err_sticky", 32'(err0), 32'd1);
      chk("ovf_err_dyn", 32'(err1), 32'd1);
      chk("ovf_mem0_kept", 32'(mem[0]), 32'hA0);
      @(negedge clk);
      push_n = 1'b1;
      @(posedge clk); #1;
      chk("ovf_err_sticky_hold", 32'(err0), 32'd1);
      chk("ovf_err_dyn_drop", 32'(err1), 32'd0);

      // Drain: head-of-queue data appears in the cycle the pop is requested.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pop_n = 1'b0;
         #1;
         chk("pop_data", 32'(rdata), 32'hA0 + 32'(i));
         chk("pop_rd_addr", 32'(ra0), 32'(i));
         chk("pop_cs_n", 32'(cs_n0), 32'd0);
         chk("pop_wr_n", 32'(wr_n0), 32'd1);
         @(posedge clk); #1;
         chk("pop_count", 32'(cnt0), 32'(7 - i));
         chk("pop_empty", 32'(empty0), 32'(i == 7));
      end

      // Pop on empty: rejected, pointer holds, error raised.
      @(negedge clk);
      #1;
      chk("unf_cs_n", 32'(cs_n0), 32'd1);
      @(posedge clk); #1;
      chk("unf_rd_addr", 32'(ra0), 32'd0);
      chk("unf_count", 32'(cnt0), 32'd0);
      chk("unf_err_dyn", 32'(err1), 32'd1);
      chk("unf_err_sticky", 32'(err0), 32'd1);
      @(negedge clk);
      pop_n = 1'b1;
      @(posedge clk); #1;
      chk("unf_err_dyn_drop", 32'(err1), 32'd0);
      chk("unf_err_sticky_hold", 32'(err0), 32'd1);

      // Asynchronous reset in the middle of a high phase with a push still requested.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         push_n = 1'b0; din = 8'hC0 + 8'(i);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(cnt0), 32'd0);
      chk("mid_rst_empty", 32'(empty0), 32'd1);
      chk("mid_rst_aempty", 32'(ae0), 32'd1);
      chk("mid_rst_wr_n", 32'(wr_n0), 32'd1);
      chk("mid_rst_error", 32'(err0), 32'd0);
      chk("mid_rst_wr_addr", 32'(wa0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; push_n = 1'b1;

      // Sticky error from an underflow alone.
      @(posedge clk); #1;
      chk("clean_err", 32'(err0), 32'd0);
      @(negedge clk);
      pop_n = 1'b0;
      @(posedge clk); #1;
      chk("unf2_err_sticky", 32'(err0), 32'd1);
      chk("unf2_rd_addr", 32'(ra0), 32'd0);
      @(negedge clk);
      pop_n = 1'b1;

      // Prime with B0..B3, then stream push+pop for 20 cycles at count 4.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         push_n = 1'b0; din = 8'hB0 + 8'(i);
         @(posedge clk); #1;
         chk("prime_count", 32'(cnt0), 32'(i + 1));
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         push_n = 1'b0; pop_n = 1'b0; din = 8'hB4 + 8'(i);
         #1;
         chk("stream_data", 32'(rdata), 32'hB0 + 32'(i));
         chk("stream_wr_n", 32'(wr_n0), 32'd0);
         chk("stream_cs_n", 32'(cs_n0), 32'd0);
         @(posedge clk); #1;
         chk("stream_count", 32'(cnt0), 32'd4);
         chk("stream_rd_addr", 32'(ra0), 32'((i + 1) % 8));
      end
      @(negedge clk);
      push_n = 1'b1; pop_n = 1'b1;

      // DEPTH=6: pointers wrap 5 -> 0.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         push2_n = 1'b0; pop2_n = 1'b1;
         #1;
         chk("d6_wr_addr", 32'(wa2), 32'(k % 6));
         chk("d6_wr_n", 32'(wr_n2), 32'd0);
         @(negedge clk);
         push2_n = 1'b1; pop2_n = 1'b0;
         #1;
         chk("d6_rd_addr", 32'(ra2), 32'(k % 6));
      end
      @(negedge clk);
      pop2_n = 1'b1;
      #1;
      chk("d6_pairs_count", 32'(cnt2), 32'd0);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         push2_n = 1'b0;
      end
      @(posedge clk); #1;
      chk("d6_full", 32'(full2), 32'd1);
      chk("d6_full_count", 32'(cnt2), 32'd6);
      chk("d6_full_wr_addr", 32'(wa2), 32'd4);
      @(negedge clk);
      pop2_n = 1'b0;
      #1;
      chk("d6_fullpp_wr_n", 32'(wr_n2), 32'd1);
      chk("d6_fullpp_cs_n", 32'(cs_n2), 32'd0);
      @(posedge clk); #1;
      chk("d6_fullpp_count", 32'(cnt2), 32'd5);
      chk("d6_fullpp_full", 32'(full2), 32'd0);
      chk("d6_fullpp_afull", 32'(af2), 32'd1);
      chk("d6_fullpp_err", 32'(err2), 32'd1);
      chk("d6_fullpp_rd_addr", 32'(ra2), 32'd5);
      @(negedge clk);
      push2_n = 1'b1; pop2_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
